// File: rtl/wb_pkg.sv
// Shared types for the write-back sequencer: register index, queued write entry,
// and the one-hot decode used for the bank write enable and the busy scoreboard.
package wb_pkg;

    localparam int REG_N  = 8;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 3;

    typedef logic [IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [REG_N-1:0] onehot(input reg_idx_t idx);
        logic [REG_N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending register writes. Besides the usual push/pop
// interface it exposes per-slot valid bits and destinations so the top can
// build the RAW-hazard busy vector without walking the queue.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t                head,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [DEPTH*IDX_W-1:0]   entry_dest
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] cnt;
    wb_entry_t        slots [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] offs;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = slots[head_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + 1'b1;
            if (do_pop)  head_ptr <= head_ptr + 1'b1;
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) slots[tail_ptr] <= push_entry;
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        entry_valid = '0;
        entry_dest  = '0;
        offs        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs           = PTR_W'(i) - head_ptr;
            entry_valid[i] = ({1'b0, offs} < cnt);
            entry_dest[i*IDX_W +: IDX_W] = slots[i].dest;
        end
    end

endmodule

// File: rtl/writeback_sequencer.sv
// Write-back stage in front of the 8x16 register bank. Arbitrates load and ALU
// results (loads win), queues them, and issues one registered one-hot bank write
// per cycle in acceptance order. busy flags registers with a write still pending.
// Optional build macro WB_BYPASS_EN: when the queue is empty and not held, an
// accepted result is written straight to the output register, saving one cycle.
module writeback_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int REG_N  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [2:0]        alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [2:0]        mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              hold,
    output logic [REG_N-1:0]  en,
    output logic [DATA_W-1:0] to_dest_reg,
    output logic [REG_N-1:0]  busy
);

    import wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    wb_entry_t              fifo_head;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH*IDX_W-1:0] entry_dest;
    wb_entry_t              push_entry;
    logic                   accept_mem;
    logic                   accept_alu;
    logic                   accepted;
    logic                   bypass;
    logic                   fifo_push;
    logic                   pop;
    logic [REG_N-1:0]       queued_mask;

    // Ready is a function of registered occupancy only; loads shadow the ALU.
    assign mem_ready  = !rst && !fifo_full;
    assign alu_ready  = !rst && !fifo_full && !mem_valid;
    assign accept_mem = mem_valid && mem_ready;
    assign accept_alu = alu_valid && alu_ready;
    assign accepted   = accept_mem || accept_alu;
    assign pop        = !hold && !fifo_empty;

`ifdef WB_BYPASS_EN
    assign bypass = accepted && !hold && (fifo_count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = accepted && !bypass;

    // Select the winning source for this cycle's single push.
    always_comb begin
        push_entry = '0;
        if (accept_mem) begin
            push_entry.dest = mem_dest;
            push_entry.data = mem_data;
        end else begin
            push_entry.dest = alu_dest;
            push_entry.data = alu_data;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_entry  (push_entry),
        .pop         (pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .head        (fifo_head),
        .entry_valid (entry_valid),
        .entry_dest  (entry_dest)
    );

    // Registered bank write: one pulse per popped (or bypassed) entry, data held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= '0;
            to_dest_reg <= '0;
        end else if (bypass) begin
            en          <= onehot(push_entry.dest);
            to_dest_reg <= push_entry.data;
        end else if (pop) begin
            en          <= onehot(fifo_head.dest);
            to_dest_reg <= fifo_head.data;
        end else begin
            en <= '0;
        end
    end

    // Busy scoreboard: every queued destination plus the write currently on en.
    always_comb begin
        queued_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) queued_mask = queued_mask | onehot(entry_dest[i*IDX_W +: IDX_W]);
        end
        busy = rst ? '0 : (queued_mask | en);
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed and randomized bench for writeback_sequencer (default build, no bypass).
module tb_writeback_sequencer;

    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_dest = '0;
    logic [15:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [2:0]  mem_dest = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        hold = 1'b0;
    logic [7:0]  en;
    logic [15:0] to_dest_reg;
    logic [7:0]  busy;

    int checks = 0;
    int errors = 0;

    writeback_sequencer #(
        .DEPTH  (4),
        .DATA_W (16),
        .REG_N  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_dest    (alu_dest),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_dest    (mem_dest),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .hold        (hold),
        .en          (en),
        .to_dest_reg (to_dest_reg),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        hold      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++; if (en !== 8'h00) begin errors++; $display("FAIL reset_en: got %h expected %h", en, 8'h00); end
        checks++; if (to_dest_reg !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected %h", to_dest_reg, 16'h0000); end
        checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy, 8'h00); end
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", alu_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b expected 0", mem_ready); end
        rst = 1'b0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_alu_ready: got %b expected 1", alu_ready); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL post_reset_mem_ready: got %b expected 1", mem_ready); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'hBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", alu_ready); end
        tick();                                  // edge N: accepted
        alu_valid = 1'b0;
        checks++; if (en !== 8'h00) begin errors++; $display("FAIL single_en_n: got %h expected %h", en, 8'h00); end
        checks++; if (busy !== 8'h08) begin errors++; $display("FAIL single_busy_n: got %h expected %h", busy, 8'h08); end
        tick();                                  // edge N+1: en asserted
        checks++; if (en !== 8'h08) begin errors++; $display("FAIL single_en: got %h expected %h", en, 8'h08); end
        checks++; if (to_dest_reg !== 16'hBEEF) begin errors++; $display("FAIL single_data: got %h expected %h", to_dest_reg, 16'hBEEF); end
        checks++; if (busy !== 8'h08) begin errors++; $display("FAIL single_busy_en: got %h expected %h", busy, 8'h08); end
        tick();
        checks++; if (en !== 8'h00) begin errors++; $display("FAIL single_en_after: got %h expected %h", en, 8'h00); end
        checks++; if (busy !== 8'h00) begin errors++; $display("FAIL single_busy_after: got %h expected %h", busy, 8'h00); end
        checks++; if (to_dest_reg !== 16'hBEEF) begin errors++; $display("FAIL single_data_held: got %h expected %h", to_dest_reg, 16'hBEEF); end
    endtask

    task automatic test_collision();
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'h0001;
        mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'h0002;
        #1;
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL coll_alu_ready: got %b expected 0", alu_ready); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL coll_mem_ready: got %b expected 1", mem_ready); end
        tick();                                  // load accepted
        mem_valid = 1'b0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL coll_alu_ready2: got %b expected 1", alu_ready); end
        tick();                                  // ALU accepted, load on en
        alu_valid = 1'b0;
        checks++; if (en !== 8'h04) begin errors++; $display("FAIL coll_en_first: got %h expected %h", en, 8'h04); end
        checks++; if (to_dest_reg !== 16'h0002) begin errors++; $display("FAIL coll_data_first: got %h expected %h", to_dest_reg, 16'h0002); end
        tick();
        checks++; if (en !== 8'h02) begin errors++; $display("FAIL coll_en_second: got %h expected %h", en, 8'h02); end
        checks++; if (to_dest_reg !== 16'h0001) begin errors++; $display("FAIL coll_data_second: got %h expected %h", to_dest_reg, 16'h0001); end
        tick();
        checks++; if (en !== 8'h00) begin errors++; $display("FAIL coll_en_idle: got %h expected %h", en, 8'h00); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_en;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_dest = 3'(i); alu_data = 16'(16'hA0 + i);
            #1;
            checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b expected 1", i, alu_ready); end
            tick();
        end
        alu_dest = 3'd4; alu_data = 16'h00A4;    // fifth offer must be held off
        #1;
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL fill_alu_full: got %b expected 0", alu_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL fill_mem_full: got %b expected 0", mem_ready); end
        checks++; if (busy !== 8'h0F) begin errors++; $display("FAIL fill_busy: got %h expected %h", busy, 8'h0F); end
        tick();
        checks++; if (en !== 8'h00) begin errors++; $display("FAIL fill_hold_en: got %h expected %h", en, 8'h00); end
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL fill_alu_still_full: got %b expected 0", alu_ready); end
        alu_valid = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_en = 8'(1 << i);
            checks++; if (en !== exp_en) begin errors++; $display("FAIL fill_drain_en_%0d: got %h expected %h", i, en, exp_en); end
            checks++; if (to_dest_reg !== 16'(16'hA0 + i)) begin errors++; $display("FAIL fill_drain_data_%0d: got %h expected %h", i, to_dest_reg, 16'(16'hA0 + i)); end
            if (i == 0) begin
                checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_return: got %b expected 1", mem_ready); end
            end
        end
        tick();
        checks++; if (en !== 8'h00) begin errors++; $display("FAIL fill_drained_en: got %h expected %h", en, 8'h00); end
        checks++; if (busy !== 8'h00) begin errors++; $display("FAIL fill_drained_busy: got %h expected %h", busy, 8'h00); end
    endtask

    task automatic test_wrap_same_dest();
        int sent = 0;
        int got = 0;
        logic acc;
        mem_valid = 1'b0;
        alu_dest  = 3'd5;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            hold      = ((cyc / 3) % 2) == 1;
            alu_valid = (sent < 10);
            alu_data  = 16'(sent);
            #1;
            acc = alu_valid && alu_ready;
            tick();
            if (acc) sent++;
            if (en !== 8'h00) begin
                checks++; if (en !== 8'h20) begin errors++; $display("FAIL wrap_en_%0d: got %h expected %h", got, en, 8'h20); end
                checks++; if (to_dest_reg !== 16'(got)) begin errors++; $display("FAIL wrap_data_%0d: got %h expected %h", got, to_dest_reg, 16'(got)); end
                got++;
            end
        end
        idle_inputs();
        checks++; if (got !== 10) begin errors++; $display("FAIL wrap_pulse_count: got %0d expected 10", got); end
        checks++; if (to_dest_reg !== 16'd9) begin errors++; $display("FAIL wrap_final_value: got %h expected %h", to_dest_reg, 16'd9); end
        tick();
        checks++; if (busy !== 8'h00) begin errors++; $display("FAIL wrap_busy_end: got %h expected %h", busy, 8'h00); end
    endtask

    task automatic test_reset_midflight();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_dest = 3'(6 + i); alu_data = 16'(16'h0C00 + i);
            tick();
        end
        alu_valid = 1'b0;
        rst  = 1'b1;
        hold = 1'b0;
        #1;
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_alu_ready: got %b expected 0", alu_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_ready: got %b expected 0", mem_ready); end
        checks++; if (busy !== 8'h00) begin errors++; $display("FAIL mid_rst_busy: got %h expected %h", busy, 8'h00); end
        tick();
        checks++; if (en !== 8'h00) begin errors++; $display("FAIL mid_rst_en: got %h expected %h", en, 8'h00); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (en !== 8'h00) begin errors++; $display("FAIL mid_after_en_%0d: got %h expected %h", i, en, 8'h00); end
            checks++; if (busy !== 8'h00) begin errors++; $display("FAIL mid_after_busy_%0d: got %h expected %h", i, busy, 8'h00); end
        end
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h1234;
        tick();
        alu_valid = 1'b0;
        tick();
        checks++; if (en !== 8'h04) begin errors++; $display("FAIL mid_new_en: got %h expected %h", en, 8'h04); end
        checks++; if (to_dest_reg !== 16'h1234) begin errors++; $display("FAIL mid_new_data: got %h expected %h", to_dest_reg, 16'h1234); end
        tick();
    endtask

    task automatic test_random();
        wb_entry_t   q[$];
        wb_entry_t   e;
        logic [7:0]  m_en;
        logic [15:0] m_data;
        logic [7:0]  exp_busy;
        logic        exp_mr;
        logic        exp_ar;
        logic        do_push;
        rst = 1'b1;
        idle_inputs();
        tick();
        rst    = 1'b0;
        m_en   = 8'h00;
        m_data = 16'h0000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            alu_valid = 1'($urandom_range(0, 1));
            mem_valid = ($urandom_range(0, 2) == 0);
            alu_dest  = 3'($urandom_range(0, 7));
            mem_dest  = 3'($urandom_range(0, 7));
            alu_data  = 16'($urandom);
            mem_data  = 16'($urandom);
            hold      = ($urandom_range(0, 3) == 0);
            #1;
            exp_mr   = (q.size() < 4);
            exp_ar   = exp_mr && !mem_valid;
            exp_busy = m_en;
            foreach (q[k]) exp_busy = exp_busy | onehot(q[k].dest);
            checks++; if (mem_ready !== exp_mr) begin errors++; $display("FAIL rnd_mem_ready_c%0d: got %b expected %b", cyc, mem_ready, exp_mr); end
            checks++; if (alu_ready !== exp_ar) begin errors++; $display("FAIL rnd_alu_ready_c%0d: got %b expected %b", cyc, alu_ready, exp_ar); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy_c%0d: got %h expected %h", cyc, busy, exp_busy); end
            do_push = 1'b0;
            e = '0;
            if (mem_valid && exp_mr) begin
                do_push = 1'b1; e.dest = mem_dest; e.data = mem_data;
            end else if (alu_valid && exp_ar) begin
                do_push = 1'b1; e.dest = alu_dest; e.data = alu_data;
            end
            if (!hold && q.size() > 0) begin
                m_en   = onehot(q[0].dest);
                m_data = q[0].data;
                void'(q.pop_front());
            end else begin
                m_en = 8'h00;
            end
            if (do_push) q.push_back(e);
            tick();
            checks++; if (en !== m_en) begin errors++; $display("FAIL rnd_en_c%0d: got %h expected %h", cyc, en, m_en); end
            checks++; if (to_dest_reg !== m_data) begin errors++; $display("FAIL rnd_data_c%0d: got %h expected %h", cyc, to_dest_reg, m_data); end
        end
        idle_inputs();
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_alu();
        test_collision();
        test_fill();
        test_wrap_same_dest();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
